// File: rtl/divmod2_pkg.sv
// Shared types and constants for the divmod2 scheduler slice.
// Holds the FSM encoding and the pointer-advance helper.
package divmod2_pkg;

    localparam int W               = 8;
    localparam int TIMEOUT_DEFAULT = 15;
    localparam int ID_W            = 3;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_CAPTURE = 2'd2,
        S_CLEAR   = 2'd3
    } state_t;

    function automatic logic [ID_W-1:0] rr_next(
        input logic [ID_W-1:0] id,
        input int              n
    );
        if (int'(id) >= n - 1)
            return '0;
        return id + 1'b1;
    endfunction

endpackage

// File: rtl/divmod2_sched_if.sv
// Requester and unit-side signal bundle of the divmod2 scheduler.
// The slave modport is the scheduler view, master is the environment.
interface divmod2_sched_if #(
    parameter int N_REQ = 4,
    parameter int W     = 8
);

    logic [N_REQ-1:0]              req;
    logic [N_REQ*W-1:0]            req_a;
    logic [N_REQ-1:0]              gnt;
    logic                          rsp_valid;
    logic [divmod2_pkg::ID_W-1:0]  rsp_id;
    logic [W-1:0]                  rsp_div;
    logic                          rsp_mod;
    logic                          rsp_err;
    logic                          busy;
    logic                          unit_activate;
    logic                          unit_clr;
    logic [W-1:0]                  unit_a;
    logic [W-1:0]                  unit_div2;
    logic                          unit_mod2;
    logic                          unit_endop;

    modport slave (
        input  req,
        input  req_a,
        input  unit_div2,
        input  unit_mod2,
        input  unit_endop,
        output gnt,
        output rsp_valid,
        output rsp_id,
        output rsp_div,
        output rsp_mod,
        output rsp_err,
        output busy,
        output unit_activate,
        output unit_clr,
        output unit_a
    );

    modport master (
        output req,
        output req_a,
        output unit_div2,
        output unit_mod2,
        output unit_endop,
        input  gnt,
        input  rsp_valid,
        input  rsp_id,
        input  rsp_div,
        input  rsp_mod,
        input  rsp_err,
        input  busy,
        input  unit_activate,
        input  unit_clr,
        input  unit_a
    );

endinterface

// File: rtl/divmod2_sched_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after i_ptr.
// The pointer register is owned by the scheduler.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = divmod2_pkg::ID_W
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_ptr,
    output logic [N_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]  o_idx,
    output logic             o_any
);

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            int j;
            j = int'(i_ptr) + k;
            if (j >= N_REQ)
                j = j - N_REQ;
            if (!o_any && i_req[j]) begin
                o_any    = 1'b1;
                o_gnt[j] = 1'b1;
                o_idx    = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/divmod2_sched.sv
// Shares one iterative divide-by-2 unit among N_REQ requesters.
// Grants round-robin, runs the unit to endop or watchdog, returns tagged result.
module divmod2_sched #(
    parameter int N_REQ   = 4,
    parameter int W       = 8,
    parameter int TIMEOUT = divmod2_pkg::TIMEOUT_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    divmod2_sched_if.slave  bus
);

    import divmod2_pkg::*;

    localparam int WD_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    state_t           r_state;
    state_t           w_next;

    logic [ID_W-1:0]  r_ptr;
    logic [ID_W-1:0]  r_id;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_div;
    logic             r_mod;
    logic             r_err;
    logic [WD_W-1:0]  r_wd;

    logic [N_REQ-1:0] w_gnt;
    logic [ID_W-1:0]  w_idx;
    logic             w_any;
    logic [W-1:0]     w_opnd;
    logic             w_tmo;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .i_req (bus.req),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    always_comb begin
        w_opnd = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_idx == ID_W'(k))
                w_opnd = bus.req_a[k*W +: W];
        end
    end

    assign w_tmo = (r_wd == WD_W'(TIMEOUT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:    if (w_any) w_next = S_RUN;
            S_RUN:     if (bus.unit_endop || w_tmo) w_next = S_CAPTURE;
            S_CAPTURE: w_next = S_CLEAR;
            S_CLEAR:   w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // endop has priority over the watchdog on the same cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
            r_id  <= '0;
            r_a   <= '0;
            r_div <= '0;
            r_mod <= 1'b0;
            r_err <= 1'b0;
            r_wd  <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_a  <= w_opnd;
                        r_id <= w_idx;
                        r_wd <= '0;
                    end
                end
                S_RUN: begin
                    if (bus.unit_endop) begin
                        r_div <= bus.unit_div2;
                        r_mod <= bus.unit_mod2;
                        r_err <= 1'b0;
                    end else if (w_tmo) begin
                        r_div <= '0;
                        r_mod <= 1'b0;
                        r_err <= 1'b1;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                S_CLEAR: r_ptr <= rr_next(r_id, N_REQ);
                default: ;
            endcase
        end
    end

    // reset gates the combinational grant so no pulse leaks while held
    assign bus.gnt = (r_state == S_IDLE && !reset) ? w_gnt : '0;

    assign bus.rsp_valid     = (r_state == S_CAPTURE);
    assign bus.rsp_id        = r_id;
    assign bus.rsp_div       = r_div;
    assign bus.rsp_mod       = r_mod;
    assign bus.rsp_err       = r_err;
    assign bus.busy          = (r_state != S_IDLE);
    assign bus.unit_activate = (r_state == S_RUN);
    assign bus.unit_clr      = reset | (r_state == S_CLEAR);
    assign bus.unit_a        = r_a;

endmodule

// File: tb/tb_divmod2_sched.sv
// Directed plus random bench for divmod2_sched with a behavioural divide-by-2 unit.
// Expected grants and results come from a round-robin reference model.
module tb_divmod2_sched;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   m_ptr = 0;
    int   k_delay = 4;
    bit   never = 1'b0;
    logic [7:0] ucnt = '0;

    divmod2_sched_if #(.N_REQ(4), .W(8)) bus();

    divmod2_sched #(.N_REQ(4), .W(8), .TIMEOUT(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // unit model: counts active cycles, endop once k_delay cycles have run
    always @(posedge clk) begin
        if (bus.unit_clr)
            ucnt <= '0;
        else if (bus.unit_activate && ucnt != 8'hFF)
            ucnt <= ucnt + 8'd1;
    end

    assign bus.unit_endop = !never && (int'(ucnt) >= k_delay);
    assign bus.unit_div2  = bus.unit_a / 8'd2;
    assign bus.unit_mod2  = bus.unit_a[0];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [3:0] rq, input int p);
        for (int o = 0; o < 4; o++)
            if (rq[(p + o) % 4]) return (p + o) % 4;
        return -1;
    endfunction

    task automatic do_op(input logic [3:0] rq, input logic [31:0] ops,
                         input int k, input bit nev, input bit hold,
                         input logic [3:0] raise);
        int id;
        int n;
        logic [7:0] a;
        bus.req   = rq;
        bus.req_a = ops;
        k_delay   = k;
        never     = nev;
        #1;
        id = rr_pick(rq, m_ptr);
        if (id < 0) id = 0;
        a = ops[id*8 +: 8];
        chk("gnt", 32'(bus.gnt), 32'(1) << id);
        chk("busy_idle", 32'(bus.busy), 0);
        tick();
        if (!hold) bus.req[id] = 1'b0;
        chk("activate", 32'(bus.unit_activate), 1);
        chk("unit_a", 32'(bus.unit_a), 32'(a));
        chk("gnt_run", 32'(bus.gnt), 0);
        n = 1;
        while (!bus.rsp_valid && n < 40) begin
            tick();
            n++;
        end
        chk("latency", n, nev ? 17 : 2 + k);
        chk("rsp_id", 32'(bus.rsp_id), id);
        chk("rsp_div", 32'(bus.rsp_div), nev ? 0 : 32'(a) / 2);
        chk("rsp_mod", 32'(bus.rsp_mod), nev ? 0 : 32'(a) % 2);
        chk("rsp_err", 32'(bus.rsp_err), nev ? 1 : 0);
        chk("act_capt", 32'(bus.unit_activate), 0);
        bus.req = bus.req | raise;
        tick();
        chk("clr_on", 32'(bus.unit_clr), 1);
        chk("valid_off", 32'(bus.rsp_valid), 0);
        tick();
        chk("clr_off", 32'(bus.unit_clr), 0);
        chk("busy_done", 32'(bus.busy), 0);
        m_ptr = (id + 1) % 4;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        m_ptr = 0;
    endtask

    initial begin
        logic [3:0]  rq;
        logic [31:0] ops;
        bus.req   = 4'b0001;
        bus.req_a = '0;
        repeat (3) tick();
        chk("rst_gnt", 32'(bus.gnt), 0);
        chk("rst_clr", 32'(bus.unit_clr), 1);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_valid", 32'(bus.rsp_valid), 0);
        chk("rst_rsp", {bus.rsp_id, bus.rsp_div, bus.rsp_mod, bus.rsp_err}, 0);
        chk("rst_unit", {bus.unit_activate, bus.unit_a}, 0);
        reset = 1'b0;
        m_ptr = 0;

        do_op(4'b0001, 32'h0000_00B5, 4, 0, 0, 4'b0000);

        do_reset();
        for (int i = 0; i < 5; i++)
            do_op(4'b1111, 32'h80FF_0201, 4, 0, 1, 4'b0000);

        bus.req = '0;
        do_op(4'b0001, $urandom, 4, 1, 0, 4'b0000);

        bus.req   = 4'b1000;
        bus.req_a = $urandom;
        k_delay   = 4;
        never     = 1'b0;
        #1;
        chk("mid_gnt", 32'(bus.gnt), 32'(1) << rr_pick(4'b1000, m_ptr));
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("mid_outs", {bus.gnt, bus.rsp_valid, bus.rsp_id, bus.rsp_div,
                         bus.rsp_mod, bus.rsp_err, bus.busy},
            0);
        chk("mid_unit", {bus.unit_activate, bus.unit_a}, 0);
        chk("mid_clr", 32'(bus.unit_clr), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid_novalid", 32'(bus.rsp_valid), 0);
        end
        reset = 1'b0;
        m_ptr = 0;
        do_op(4'b1001, $urandom, 4, 0, 0, 4'b0000);
        do_op(bus.req, $urandom, 4, 0, 0, 4'b0000);

        do_op(4'b0100, $urandom, 4, 0, 1, 4'b0010);
        do_op(bus.req, $urandom, 4, 0, 0, 4'b0000);
        bus.req = '0;

        do_op(4'b0010, $urandom, 0, 0, 0, 4'b0000);

        for (int i = 0; i < 24; i++) begin
            rq  = bus.req | 4'($urandom_range(1, 15));
            ops = $urandom;
            do_op(rq, ops, $urandom_range(0, 6), 0,
                  1'($urandom_range(0, 1)), 4'b0000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
